// File: rtl/demux_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : demux_pkg
// Brief  : Shared defaults and counter width for the stream demultiplexer.
// Rev    : 1.0
// ---------------------------------------------------------------------------
package demux_pkg;

  localparam int unsigned C_DEF_WIDTH    = 8;
  localparam int unsigned C_DEF_CHANNELS = 8;
  localparam int unsigned C_CNT_W        = 16;

  typedef logic [C_CNT_W-1:0] beat_cnt_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_chan_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : demux_chan_reg
// Brief  : Single-entry output register for one demux channel.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module demux_chan_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data_out
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A load in the same cycle as a drain wins, keeping the channel full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= data_in;
    end else if (ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid    = r_valid;
  assign data_out = r_data;

endmodule : demux_chan_reg
`default_nettype wire

// File: rtl/demux_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : demux_stream
// Brief  : Unicast/broadcast stream demultiplexer with per-channel register.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module demux_stream
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH    = C_DEF_WIDTH,
  parameter int unsigned CHANNELS = C_DEF_CHANNELS,
  parameter int unsigned SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SELW-1:0]           in_sel,
  input  logic                      in_bcast,
  output logic                      in_ready,
  output logic [CHANNELS-1:0]       out_valid,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      sel_err,
  output logic [C_CNT_W-1:0]        beat_cnt
);

  logic [CHANNELS-1:0]      w_free;
  logic [CHANNELS-1:0]      w_load;
  logic [(1<<SELW)-1:0]     w_free_ext;
  logic                     w_in_range;
  logic                     w_accept;
  logic                     r_sel_err;
  beat_cnt_t                r_beat_cnt;

  assign w_free = ~out_valid | out_ready;

  // With a power-of-two channel count every select value is legal.
  generate
    if ((1 << SELW) == CHANNELS) begin : g_pow2
      assign w_in_range = 1'b1;
    end else begin : g_range_chk
      localparam logic [SELW:0] c_channels = (SELW+1)'(CHANNELS);
      assign w_in_range = ({1'b0, in_sel} < c_channels);
    end
  endgenerate

  always_comb begin
    w_free_ext                 = '0;
    w_free_ext[CHANNELS-1:0]   = w_free;
  end

  always_comb begin
    if (in_bcast)        in_ready = &w_free;
    else if (w_in_range) in_ready = w_free_ext[in_sel];
    else                 in_ready = 1'b1;
  end

  assign w_accept = in_valid & in_ready;

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      assign w_load[k] = w_accept & (in_bcast | (w_in_range & (in_sel == SELW'(k))));

      demux_chan_reg #(
        .WIDTH (WIDTH)
      ) u_chan (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load[k]),
        .data_in  (in_data),
        .ready    (out_ready[k]),
        .valid    (out_valid[k]),
        .data_out (out_data[k*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Dropped out-of-range beats flag an error but never count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err  <= 1'b0;
      r_beat_cnt <= '0;
    end else begin
      r_sel_err <= w_accept & ~in_bcast & ~w_in_range;
      if (w_accept & (in_bcast | w_in_range))
        r_beat_cnt <= r_beat_cnt + 1'b1;
    end
  end

  assign sel_err  = r_sel_err;
  assign beat_cnt = r_beat_cnt;

endmodule : demux_stream
`default_nettype wire

// File: tb/tb_demux_stream.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_demux_stream
// Brief  : Self-checking bench: reference model plus directed literal checks.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_demux_stream;

  localparam int CH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_bcast;
  logic        in_ready;
  logic [7:0]  out_valid;
  logic [63:0] out_data;
  logic [7:0]  out_ready;
  logic        sel_err;
  logic [15:0] beat_cnt;

  logic        in_valid6;
  logic [7:0]  in_data6;
  logic [2:0]  in_sel6;
  logic        in_ready6;
  logic [5:0]  out_valid6;
  logic [47:0] out_data6;
  logic        sel_err6;
  logic [15:0] beat_cnt6;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  demux_stream dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel_err(sel_err), .beat_cnt(beat_cnt)
  );

  demux_stream #(.WIDTH(8), .CHANNELS(6), .SELW(3)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .in_data(in_data6),
    .in_sel(in_sel6), .in_bcast(1'b0), .in_ready(in_ready6),
    .out_valid(out_valid6), .out_data(out_data6), .out_ready(6'h3F),
    .sel_err(sel_err6), .beat_cnt(beat_cnt6)
  );

  // Reference model: one slot per channel, a beat counter and an error flag.
  logic       m_valid [CH];
  logic [7:0] m_data  [CH];
  logic [15:0] m_cnt;
  logic        m_err;

  function automatic logic f_ready(input logic bc, input logic [2:0] sel, input logic [7:0] ordy);
    logic all_free;
    all_free = 1'b1;
    for (int k = 0; k < CH; k++)
      if (m_valid[k] && !ordy[k]) all_free = 1'b0;
    if (bc) return all_free;
    if (int'(sel) >= CH) return 1'b1;
    return !m_valid[sel] || ordy[sel];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic acc;
    if (!rst_n) begin
      for (int k = 0; k < CH; k++) begin
        m_valid[k] <= 1'b0;
        m_data[k]  <= 8'h00;
      end
      m_cnt <= 16'h0;
      m_err <= 1'b0;
    end else begin
      acc = in_valid && f_ready(in_bcast, in_sel, out_ready);
      m_err <= acc && !in_bcast && (int'(in_sel) >= CH);
      for (int k = 0; k < CH; k++) begin
        if (acc && (in_bcast || int'(in_sel) == k)) begin
          m_valid[k] <= 1'b1;
          m_data[k]  <= in_data;
        end else if (out_ready[k]) begin
          m_valid[k] <= 1'b0;
        end
      end
      if (acc && (in_bcast || int'(in_sel) < CH)) m_cnt <= m_cnt + 16'd1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [7:0]  ev;
    logic [63:0] ed, mask;
    ev = '0; ed = '0; mask = '0;
    for (int k = 0; k < CH; k++) begin
      ev[k] = m_valid[k];
      if (m_valid[k]) begin
        mask[k*8 +: 8] = 8'hFF;
        ed[k*8 +: 8]   = m_data[k];
      end
    end
    chk("model out_valid", {56'h0, out_valid}, {56'h0, ev});
    chk("model out_data", out_data & mask, ed);
    chk("model in_ready", {63'h0, in_ready}, {63'h0, f_ready(in_bcast, in_sel, out_ready)});
    chk("model sel_err", {63'h0, sel_err}, {63'h0, m_err});
    chk("model beat_cnt", {48'h0, beat_cnt}, {48'h0, m_cnt});
    if (!rst_n) chk("reset out_data", out_data, 64'h0);
  endtask

  // Compare against the model away from the edge, then advance one cycle.
  task automatic step();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [7:0] d, input logic [2:0] s, input logic b);
    in_valid = v; in_data = d; in_sel = s; in_bcast = b;
  endtask

  initial begin
    rst_n = 1'b0;
    put(1'b0, 8'h00, 3'd0, 1'b0);
    out_ready = 8'hFF;
    in_valid6 = 1'b0; in_data6 = 8'h00; in_sel6 = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", {56'h0, out_valid}, 64'h0);
    chk("reset beat_cnt", {48'h0, beat_cnt}, 64'h0);
    chk("reset out_data", out_data, 64'h0);

    // Unicast sweep; the first beat is offered across reset release.
    put(1'b1, 8'hAA, 3'd0, 1'b0);
    #3 rst_n = 1'b1;
    step();
    chk("sweep valid 0", {56'h0, out_valid}, 64'h01);
    for (int k = 1; k < CH; k++) begin
      put(1'b1, 8'hAA, 3'(k), 1'b0);
      step();
      chk($sformatf("sweep valid %0d", k), {56'h0, out_valid}, 64'h1 << k);
      chk($sformatf("sweep data %0d", k), {56'h0, out_data[k*8 +: 8]}, 64'hAA);
    end
    put(1'b0, 8'h00, 3'd0, 1'b0);
    chk("sweep beat_cnt", {48'h0, beat_cnt}, 64'd8);
    step();

    // Back-pressure on channel 3.
    out_ready = 8'hF7;
    put(1'b1, 8'h11, 3'd3, 1'b0);
    #1 chk("stall first ready", {63'h0, in_ready}, 64'h1);
    step();
    put(1'b1, 8'h22, 3'd3, 1'b0);
    #1 chk("stall second ready", {63'h0, in_ready}, 64'h0);
    step();
    chk("stall hold data", {56'h0, out_data[24 +: 8]}, 64'h11);
    step();
    chk("stall hold data 2", {56'h0, out_data[24 +: 8]}, 64'h11);
    out_ready = 8'hFF;
    #1 chk("stall release ready", {63'h0, in_ready}, 64'h1);
    step();
    chk("stall new data", {56'h0, out_data[24 +: 8]}, 64'h22);
    put(1'b0, 8'h00, 3'd0, 1'b0);
    chk("stall beat_cnt", {48'h0, beat_cnt}, 64'd10);
    step();

    // Broadcast blocked by a full, stalled channel 6.
    out_ready = 8'hBF;
    put(1'b1, 8'h66, 3'd6, 1'b0);
    step();
    put(1'b1, 8'h5C, 3'd2, 1'b1);
    #1 chk("bcast blocked ready", {63'h0, in_ready}, 64'h0);
    step();
    chk("bcast blocked valid", {56'h0, out_valid}, 64'h40);
    chk("bcast blocked data", {56'h0, out_data[48 +: 8]}, 64'h66);
    chk("bcast blocked cnt", {48'h0, beat_cnt}, 64'd11);
    out_ready = 8'hFF;
    #1 chk("bcast ready", {63'h0, in_ready}, 64'h1);
    step();
    chk("bcast valid", {56'h0, out_valid}, 64'hFF);
    chk("bcast data", out_data, {8{8'h5C}});
    chk("bcast cnt", {48'h0, beat_cnt}, 64'd12);
    put(1'b0, 8'h00, 3'd0, 1'b0);
    step();

    // Six-channel instance: out-of-range select.
    in_valid6 = 1'b1; in_data6 = 8'h77; in_sel6 = 3'd7;
    #1 chk("ch6 oor ready", {63'h0, in_ready6}, 64'h1);
    step();
    chk("ch6 sel_err pulse", {63'h0, sel_err6}, 64'h1);
    chk("ch6 oor valid", {58'h0, out_valid6}, 64'h0);
    chk("ch6 oor cnt", {48'h0, beat_cnt6}, 64'h0);
    in_valid6 = 1'b0;
    step();
    chk("ch6 sel_err clear", {63'h0, sel_err6}, 64'h0);
    chk("ch6 oor valid 2", {58'h0, out_valid6}, 64'h0);
    in_valid6 = 1'b1; in_data6 = 8'h3C; in_sel6 = 3'd5;
    step();
    chk("ch6 valid", {58'h0, out_valid6}, 64'h20);
    chk("ch6 data", {56'h0, out_data6[40 +: 8]}, 64'h3C);
    chk("ch6 cnt", {48'h0, beat_cnt6}, 64'h1);
    chk("ch6 no err", {63'h0, sel_err6}, 64'h0);
    in_valid6 = 1'b0;
    step();

    // Randomized traffic, checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      put(($urandom % 100) < 70, 8'($urandom), 3'($urandom_range(0, 7)), ($urandom % 10) == 0);
      out_ready = 8'($urandom) | 8'($urandom);
      step();
    end
    put(1'b0, 8'h00, 3'd0, 1'b0);
    out_ready = 8'hFF;
    step();
    step();

    // Asynchronous reset mid-stream with channels 2 and 5 held.
    out_ready = 8'hDB;
    put(1'b1, 8'hA2, 3'd2, 1'b0);
    step();
    put(1'b1, 8'hA5, 3'd5, 1'b0);
    step();
    put(1'b0, 8'h00, 3'd0, 1'b0);
    chk("pre-reset valid", {56'h0, out_valid}, 64'h24);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset valid", {56'h0, out_valid}, 64'h0);
    chk("async reset cnt", {48'h0, beat_cnt}, 64'h0);
    chk("async reset data", out_data, 64'h0);
    chk("async reset err", {63'h0, sel_err}, 64'h0);
    put(1'b1, 8'hEE, 3'd1, 1'b0);
    step();
    chk("reset beat dropped", {56'h0, out_valid}, 64'h0);
    #3 rst_n = 1'b1;
    out_ready = 8'hFF;
    put(1'b1, 8'hB7, 3'd4, 1'b0);
    step();
    chk("post-reset valid", {56'h0, out_valid}, 64'h10);
    chk("post-reset data", {56'h0, out_data[32 +: 8]}, 64'hB7);
    chk("post-reset cnt", {48'h0, beat_cnt}, 64'h1);
    put(1'b0, 8'h00, 3'd0, 1'b0);
    step();

    // Counter wrap.
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      put(1'b1, 8'(i), 3'(i % 8), 1'b0);
      step();
    end
    chk("cnt at max", {48'h0, beat_cnt}, 64'hFFFF);
    put(1'b1, 8'h99, 3'd1, 1'b0);
    step();
    chk("cnt wrap", {48'h0, beat_cnt}, 64'h0);
    put(1'b0, 8'h00, 3'd0, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_demux_stream
`default_nettype wire
